// File: rtl/jpeg_rle_coef_decoder.sv
// Run-length decoder: expands (run, coef, eob) symbols into 64 zig-zag ordered
// coefficients per 8x8 block, one per cycle through a registered output slot.
module jpeg_rle_coef_decoder #(
   parameter int unsigned COEF_W  = 12,
   parameter int unsigned BLK_LEN = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     sym_valid,
   output logic                     sym_ready,
   input  logic [3:0]               sym_run,
   input  logic signed [COEF_W-1:0] sym_coef,
   input  logic                     sym_eob,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [COEF_W-1:0] out_coef,
   output logic [5:0]               out_idx,
   output logic                     out_last,
   output logic                     err_ovf,
   input  logic                     err_clr
);

   localparam logic [5:0] LAST_IDX = 6'(BLK_LEN - 1);

   typedef enum logic [1:0] {StDc, StAc, StZeros, StFlush} state_t;

   state_t                   state;
   logic [5:0]               idx;
   logic [3:0]               remaining;
   logic signed [COEF_W-1:0] pend_coef;
   logic                     armed;
   logic                     slot_free;
   logic                     accept;
   logic                     at_end;

   // armed keeps sym_ready low until the first clock edge after reset release
   always_comb begin
      slot_free = !out_valid || out_ready;
      sym_ready = armed && (state == StDc || state == StAc) && slot_free;
      accept    = sym_valid && sym_ready;
      at_end    = (idx == LAST_IDX);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= StDc;
         idx       <= '0;
         remaining <= '0;
         pend_coef <= '0;
         armed     <= 1'b0;
         out_valid <= 1'b0;
         out_coef  <= '0;
         out_idx   <= '0;
         out_last  <= 1'b0;
         err_ovf   <= 1'b0;
      end else begin
         armed <= 1'b1;
         // a same-cycle overflow below overrides this clear
         if (err_clr) err_ovf <= 1'b0;
         if (out_valid && out_ready) out_valid <= 1'b0;
         if (slot_free) begin
            unique case (state)
               StDc: begin
                  if (accept) begin
                     out_valid <= 1'b1;
                     out_coef  <= sym_coef;
                     out_idx   <= '0;
                     out_last  <= 1'b0;
                     idx       <= 6'd1;
                     state     <= StAc;
                  end
               end
               StAc: begin
                  if (accept) begin
                     out_valid <= 1'b1;
                     out_idx   <= idx;
                     out_last  <= at_end;
                     idx       <= idx + 6'd1;
                     if (sym_eob) begin
                        out_coef <= '0;
                        state    <= at_end ? StDc : StFlush;
                     end else if (sym_run == 4'd0) begin
                        out_coef <= sym_coef;
                        state    <= at_end ? StDc : StAc;
                     end else begin
                        // first zero of the run goes out on the accept edge
                        out_coef  <= '0;
                        pend_coef <= sym_coef;
                        remaining <= sym_run - 4'd1;
                        if (at_end) begin
                           err_ovf <= 1'b1;
                           state   <= StDc;
                        end else begin
                           state <= StZeros;
                        end
                     end
                  end
               end
               StZeros: begin
                  out_valid <= 1'b1;
                  out_idx   <= idx;
                  out_last  <= at_end;
                  idx       <= idx + 6'd1;
                  if (remaining != 4'd0) begin
                     out_coef  <= '0;
                     remaining <= remaining - 4'd1;
                     // a zero at the last index leaves no room for the pending coef
                     if (at_end) begin
                        err_ovf <= 1'b1;
                        state   <= StDc;
                     end
                  end else begin
                     out_coef <= pend_coef;
                     state    <= at_end ? StDc : StAc;
                  end
               end
               StFlush: begin
                  out_valid <= 1'b1;
                  out_coef  <= '0;
                  out_idx   <= idx;
                  out_last  <= at_end;
                  idx       <= idx + 6'd1;
                  if (at_end) state <= StDc;
               end
               default: state <= StDc;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_jpeg_rle_coef_decoder.sv
// Directed bench for jpeg_rle_coef_decoder: symbol sequences with hand-computed
// 64-entry expected blocks, back-pressure hold checks and async reset.
module tb_jpeg_rle_coef_decoder;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              sym_valid = 1'b0;
   logic              sym_ready;
   logic [3:0]        sym_run = '0;
   logic signed [11:0] sym_coef = '0;
   logic              sym_eob = 1'b0;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic signed [11:0] out_coef;
   logic [5:0]        out_idx;
   logic              out_last;
   logic              err_ovf;
   logic              err_clr = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;
   bit bp_mode  = 1'b0;

   int cap_coef[$];
   int cap_idx[$];
   int cap_last[$];
   int exp_coef[64];

   logic               stall_q = 1'b0;
   logic signed [11:0] prev_coef;
   logic [5:0]         prev_idx;
   logic               prev_last;

   jpeg_rle_coef_decoder #(.COEF_W(12), .BLK_LEN(64)) dut (
      .clk       (clk),
      .rst       (rst),
      .sym_valid (sym_valid),
      .sym_ready (sym_ready),
      .sym_run   (sym_run),
      .sym_coef  (sym_coef),
      .sym_eob   (sym_eob),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_coef  (out_coef),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .err_ovf   (err_ovf),
      .err_clr   (err_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic signed [31:0] got,
                      input logic signed [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   // out_ready changes shortly after each rising edge, never near a sample point
   always @(posedge clk) begin
      #2;
      out_ready = bp_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
   end

   always @(negedge clk) begin
      if (stall_q) begin
         chk("hold_valid", out_valid, 1);
         chk("hold_coef", out_coef, prev_coef);
         chk("hold_idx", out_idx, prev_idx);
         chk("hold_last", out_last, prev_last);
      end
      if (!rst && out_valid && !out_ready) chk("sym_ready_busy", sym_ready, 0);
      if (!rst && out_valid && out_ready) begin
         cap_coef.push_back(int'(out_coef));
         cap_idx.push_back(int'(out_idx));
         cap_last.push_back(int'(out_last));
      end
      stall_q   = !rst && out_valid && !out_ready;
      prev_coef = out_coef;
      prev_idx  = out_idx;
      prev_last = out_last;
   end

   task automatic send(input logic [3:0] run, input logic signed [11:0] coef, input logic eob);
      int k;
      @(negedge clk);
      sym_run   = run;
      sym_coef  = coef;
      sym_eob   = eob;
      sym_valid = 1'b1;
      k = 0;
      while (sym_ready !== 1'b1 && k < 500) begin
         @(negedge clk);
         k++;
      end
      chk("sym_accept", sym_ready, 1);
      @(posedge clk);
      #1;
      sym_valid = 1'b0;
   endtask

   task automatic clear_cap();
      cap_coef.delete();
      cap_idx.delete();
      cap_last.delete();
   endtask

   task automatic clear_exp();
      for (int i = 0; i < 64; i++) exp_coef[i] = 0;
   endtask

   task automatic check_block(input string tag);
      int k;
      k = 0;
      while (cap_coef.size() < 64 && k < 3000) begin
         @(negedge clk);
         k++;
      end
      repeat (4) @(negedge clk);
      chk({tag, "_count"}, cap_coef.size(), 64);
      for (int i = 0; i < 64; i++) begin
         if (i < cap_coef.size()) begin
            chk($sformatf("%s_coef%0d", tag, i), cap_coef[i], exp_coef[i]);
            chk($sformatf("%s_idx%0d", tag, i), cap_idx[i], i);
            chk($sformatf("%s_last%0d", tag, i), cap_last[i], (i == 63) ? 1 : 0);
         end
      end
   endtask

   initial begin
      int k;
      // reset state
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_valid", out_valid, 0);
      chk("rst_coef", out_coef, 0);
      chk("rst_idx", out_idx, 0);
      chk("rst_last", out_last, 0);
      chk("rst_err", err_ovf, 0);
      chk("rst_ready", sym_ready, 0);
      rst = 1'b0;
      chk("release_ready", sym_ready, 0);
      @(negedge clk);
      chk("armed_ready", sym_ready, 1);

      // basic block, plus first-output latency
      clear_cap();
      clear_exp();
      exp_coef[0] = 37; exp_coef[1] = -5; exp_coef[4] = 3;
      send(4'd0, 12'sd37, 1'b0);
      chk("lat_valid", out_valid, 1);
      chk("lat_coef", out_coef, 37);
      chk("lat_idx", out_idx, 0);
      send(4'd0, -12'sd5, 1'b0);
      send(4'd2, 12'sd3, 1'b0);
      send(4'd0, 12'sd0, 1'b1);
      check_block("basic");
      chk("basic_err", err_ovf, 0);

      // three ZRLs then (14,+1) lands exactly on idx 63
      clear_cap();
      clear_exp();
      exp_coef[63] = 1;
      send(4'd0, 12'sd0, 1'b0);
      repeat (3) send(4'd15, 12'sd0, 1'b0);
      send(4'd14, 12'sd1, 1'b0);
      check_block("zrl");
      chk("zrl_err", err_ovf, 0);

      // overflow: pending +2 dropped, next symbol is a DC
      clear_cap();
      clear_exp();
      exp_coef[0] = 1;
      send(4'd0, 12'sd1, 1'b0);
      repeat (3) send(4'd15, 12'sd0, 1'b0);
      send(4'd15, 12'sd2, 1'b0);
      check_block("ovf");
      chk("ovf_err_set", err_ovf, 1);
      repeat (5) @(negedge clk);
      chk("ovf_err_sticky", err_ovf, 1);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk("ovf_err_clr", err_ovf, 0);

      // basic block again under random back-pressure
      bp_mode = 1'b1;
      clear_cap();
      clear_exp();
      exp_coef[0] = 37; exp_coef[1] = -5; exp_coef[4] = 3;
      send(4'd0, 12'sd37, 1'b0);
      send(4'd0, -12'sd5, 1'b0);
      send(4'd2, 12'sd3, 1'b0);
      send(4'd0, 12'sd0, 1'b1);
      check_block("bp");
      bp_mode = 1'b0;
      repeat (3) @(negedge clk);

      // async reset mid-flush
      clear_cap();
      send(4'd0, 12'sd5, 1'b0);
      send(4'd0, 12'sd0, 1'b1);
      k = 0;
      while (!(out_valid === 1'b1 && out_idx === 6'd20) && k < 500) begin
         @(negedge clk);
         k++;
      end
      chk("flush_idx20", out_idx, 20);
      #1 rst = 1'b1;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_idx", out_idx, 0);
      chk("mid_rst_ready", sym_ready, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("mid_release_ready", sym_ready, 0);
      clear_cap();
      clear_exp();
      exp_coef[0] = 9;
      send(4'd0, 12'sd9, 1'b0);
      send(4'd0, 12'sd0, 1'b1);
      check_block("post_rst");

      // eob/run on a DC symbol are ignored
      clear_cap();
      clear_exp();
      exp_coef[0] = -100; exp_coef[1] = 4;
      send(4'd7, -12'sd100, 1'b1);
      send(4'd0, 12'sd4, 1'b0);
      send(4'd0, 12'sd0, 1'b1);
      check_block("dc_eob");
      chk("final_err", err_ovf, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/jpeg_rle_coef_decoder.md
Name: jpeg_rle_coef_decoder

Overview:
- Run-length decoder for the JPEG entropy path. Converts (run, coefficient, EOB) symbols from the Huffman/VLI decode stage into a dense stream of 64 zig-zag-ordered quantised coefficients per 8x8 block.
- Output feeds dequantisation/IDCT.
- It is the decode-side counterpart of the coefficient run-length encoder cone and sits between the symbol decoder and the dezigzag buffer.

Parameters:
COEF_W, 12, signed coefficient width (sym_coef, out_coef)
BLK_LEN, 64, coefficients per block; fixed at 64, index width 6

Ports:
clk  input  1  clock, all state rising-edge
rst  input  1  asynchronous active-high reset
sym_valid  input  1  symbol present
sym_ready  output  1  decoder accepts symbol this cycle
sym_run  input  4  zeros preceding coefficient (0..15); ignored on DC symbol
sym_coef  input  COEF_W  signed coefficient value
sym_eob  input  1  end-of-block: remaining coefficients are zero; ignored on DC symbol
out_valid  output  1  out_coef/out_idx valid
out_ready  input  1  downstream accepts
out_coef  output  COEF_W  coefficient
out_idx  output  6  zig-zag index 0..63
out_last  output  1  high with idx 63
err_ovf  output  1  sticky: run overflowed block
err_clr  input  1  synchronous clear of err_ovf

Behaviour:
- Reset (async, any time, including mid-block): state=DC, idx=0, out_valid=0, out_coef=0, out_idx=0, out_last=0, err_ovf=0, sym_ready=0 until first clock after deassert. Partial block is discarded.
- Output is a register slot. Slot free = !out_valid || out_ready. A transfer occurs on out_valid&&out_ready. While out_valid=1 and out_ready=0, out_coef/out_idx/out_last hold stable.
- States:
  - DC: expect first symbol of a block.
  - AC: expect run/coef symbol.
  - ZEROS: emitting run zeros, then pending coefficient.
  - FLUSH: EOB zero fill to idx 63.
- sym_ready = (state==DC || state==AC) && slot free. It is combinational from state and the output handshake. It never depends on sym_valid.
- DC accept: load slot with {sym_coef, idx 0} on the same edge (latency 1 cycle). Go to AC; idx=1.
- AC accept, sym_eob=1: go to FLUSH. Emit zeros idx..63, one per free-slot cycle; out_last on idx 63. Then go to DC.
- AC accept, run=0: load coef at idx. If idx==63, set out_last and go to DC; else idx+1.
- AC accept, run>0: latch coef and remaining=run. Go to ZEROS and emit run zeros, then the latched coef, one per free-slot cycle. Return to AC (or DC if the coef lands on idx 63).
- ZRL (run=15, coef=0) needs no special case: it yields 16 zeros.
- Overflow: if a zero or the pending coef would need idx>63, the zero at idx 63 carries out_last. The remaining zeros and the pending coef are dropped, err_ovf is set, and state goes to DC.
- err_ovf: set has priority over err_clr in the same cycle.
- Throughput: 1 coefficient per cycle sustained when out_ready=1. Symbol accept never inserts a bubble when the next symbol is waiting in DC/AC.
- idx wraps to 0 exactly when out_last is loaded. Exactly 64 outputs per block, always, including error cases.

Test Plan:
- Symbols DC=+37, (0,-5), (2,+3), EOB with out_ready=1 -> 64 outputs: idx0=37, idx1=-5, idx2..3=0, idx4=3, idx5..63=0. out_last only at idx63. err_ovf=0. First output 1 cycle after DC accept.
- DC=0 then 3x ZRL (15,0) then (14,+1) -> idx1..62=0, idx63=+1 with out_last. Next symbol is treated as DC.
- DC=1, (15,0)x3, (15,+2) -> zeros through idx63 with out_last, coef +2 dropped. err_ovf=1 and stays 1 until an err_clr pulse.
- Back-pressure: out_ready toggled 0/1 randomly during the first scenario -> identical value/idx sequence. Outputs stable while stalled. sym_ready=0 whenever slot busy.
- rst asserted asynchronously mid-FLUSH at idx 20 -> out_valid=0 immediately. After release, DC=+9, EOB -> clean block idx0=9, rest 0.
- sym_eob=1 and run=7 on the DC symbol with coef -100 -> treated as DC: idx0=-100, no flush started, state AC.
